// File: rtl/mba_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mba_rr_arbiter
//   Shares one Modified Booth multiplier core between NUM_REQ requesters.
//   A round-robin arbiter accepts one operand pair at a time. It truncates the
//   operands to the core width and strobes them into the core. It then waits
//   for the core's product and returns it sign-extended to AXI_SIZE, tagged
//   with the index of the requester that owns it.
//
//   Optional feature macro: MBA_ARB_TIMEOUT_EN
//     When defined, a WAIT-state watchdog answers with rsp_error=1 and
//     rsp_data=0 after TIMEOUT_CYCLES cycles without a core result.
//     When undefined, WAIT holds indefinitely and rsp_error is tied to 0.
//
// Ports
//   clock        in   clock
//   reset        in   synchronous reset, active-low
//   req_valid    in   [NUM_REQ]           operand pair pending per requester
//   req_ready    out  [NUM_REQ]           one-hot grant, only in IDLE
//   req_a/req_b  in   [NUM_REQ*AXI_SIZE]  flat operands, requester i at [i*AXI_SIZE +: AXI_SIZE]
//   MBA_A/MBA_B  out  [MBA_SIZE_IN]       operands to the core, 0 unless MBA_val
//   MBA_val      out                      one-cycle start strobe to the core
//   MBA_out      in   [MBA_SIZE_OUT]      signed product from the core
//   MBA_out_val  in                       product valid strobe from the core
//   rsp_data     out  [AXI_SIZE]          sign-extended product (held between responses)
//   rsp_id       out  [ID_W]              owner of rsp_data
//   rsp_valid    out                      one-cycle response strobe
//   rsp_error    out                      watchdog timeout flag, qualified by rsp_valid
// ---------------------------------------------------------------------------
module mba_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AXI_SIZE       = 32,
    parameter int MBA_SIZE_IN    = 5,
    parameter int MBA_SIZE_OUT   = 10,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ID_W          = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*AXI_SIZE-1:0]   req_a,
    input  logic [NUM_REQ*AXI_SIZE-1:0]   req_b,
    output logic [MBA_SIZE_IN-1:0]        MBA_A,
    output logic [MBA_SIZE_IN-1:0]        MBA_B,
    output logic                          MBA_val,
    input  logic signed [MBA_SIZE_OUT-1:0] MBA_out,
    input  logic                          MBA_out_val,
    output logic [AXI_SIZE-1:0]           rsp_data,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_valid,
    output logic                          rsp_error
);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1 || MBA_SIZE_OUT > AXI_SIZE || MBA_SIZE_IN > AXI_SIZE)
    begin : g_param_check
        $error("mba_rr_arbiter: invalid parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                   state;
    logic [ID_W-1:0]          last_grant;
    logic [ID_W-1:0]          cur_id;
    logic [ID_W-1:0]          grant_idx;
    logic [ID_W-1:0]          cand;
    logic                     grant_found;
    logic                     accept;
    logic [MBA_SIZE_IN-1:0]   op_a;
    logic [MBA_SIZE_IN-1:0]   op_b;
    logic                     unused_bits;

`ifdef MBA_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]         wait_cnt;
    logic                     err_flag;
    assign rsp_error = err_flag;
`else
    assign rsp_error = 1'b0;
`endif

    // Only the low MBA_SIZE_IN bits of each operand reach the core.
    assign unused_bits = ^{req_a, req_b};

    function automatic logic [AXI_SIZE-1:0] sext_product(input logic signed [MBA_SIZE_OUT-1:0] p);
        return {{(AXI_SIZE-MBA_SIZE_OUT){p[MBA_SIZE_OUT-1]}}, p};
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + 1 + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_idx   = cand;
                grant_found = 1'b1;
            end
        end
    end

    // Grant is suppressed while reset is held so nothing is accepted at the reset edge.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && reset && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    assign accept    = |(req_valid & req_ready);
    assign MBA_val   = (state == S_ISSUE);
    assign MBA_A     = MBA_val ? op_a : '0;
    assign MBA_B     = MBA_val ? op_b : '0;
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_data   <= '0;
            rsp_id     <= '0;
`ifdef MBA_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
            err_flag   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a       <= req_a[grant_idx*AXI_SIZE +: MBA_SIZE_IN];
                        op_b       <= req_b[grant_idx*AXI_SIZE +: MBA_SIZE_IN];
                        cur_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A zero-latency core answers in the same cycle as the strobe.
                    if (MBA_out_val) begin
                        rsp_data <= sext_product(MBA_out);
                        rsp_id   <= cur_id;
`ifdef MBA_ARB_TIMEOUT_EN
                        err_flag <= 1'b0;
`endif
                        state    <= S_RESP;
                    end else begin
`ifdef MBA_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A real result beats a watchdog expiry in the same cycle.
                    if (MBA_out_val) begin
                        rsp_data <= sext_product(MBA_out);
                        rsp_id   <= cur_id;
`ifdef MBA_ARB_TIMEOUT_EN
                        err_flag <= 1'b0;
`endif
                        state    <= S_RESP;
                    end
`ifdef MBA_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data <= '0;
                        rsp_id   <= cur_id;
                        err_flag <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mba_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mba_rr_arbiter
//   Directed bench for mba_rr_arbiter. Stimulus pushes the expected core
//   operands and the expected responses into queues. A behavioural core model
//   and a response monitor pop and compare whenever the DUT presents
//   MBA_val or rsp_valid.
// ---------------------------------------------------------------------------
module tb_mba_rr_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int MI = 5;
    localparam int MO = 10;
    localparam int TO = 8;
    localparam int IW = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0]        req_ready;
    logic [NR*AW-1:0]     req_a = '0;
    logic [NR*AW-1:0]     req_b = '0;
    logic [MI-1:0]        MBA_A, MBA_B;
    logic                 MBA_val;
    logic [MO-1:0]        MBA_out = '0;
    logic                 MBA_out_val = 1'b0;
    logic [AW-1:0]        rsp_data;
    logic [IW-1:0]        rsp_id;
    logic                 rsp_valid;
    logic                 rsp_error;

    always #5 clock = ~clock;

    mba_rr_arbiter #(
        .NUM_REQ(NR), .AXI_SIZE(AW), .MBA_SIZE_IN(MI), .MBA_SIZE_OUT(MO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .MBA_A(MBA_A), .MBA_B(MBA_B), .MBA_val(MBA_val),
        .MBA_out(MBA_out), .MBA_out_val(MBA_out_val),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_valid(rsp_valid), .rsp_error(rsp_error)
    );

    typedef struct packed {
        logic          err;
        logic [IW-1:0] id;
        logic [AW-1:0] data;
    } rsp_t;

    rsp_t             rsp_q[$];
    logic [2*MI-1:0]  op_q[$];
    int checks = 0;
    int passes = 0;
    int lat = 1;
    bit core_on = 1'b1;
    bit stray_tog = 1'b0;
    bit stray_done = 1'b0;

    task automatic check(input bit ok, input string msg);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s", msg);
    endtask

    // Behavioural MBA core: answers lat cycles after the start strobe.
    bit                   pend = 1'b0;
    int                   cnt_m = 0;
    logic [MO-1:0]        prod;
    logic signed [MO-1:0] sa, sb;
    logic [2*MI-1:0]      exp_op;
    always @(negedge clock) begin
        MBA_out_val = 1'b0;
        if (!reset) pend = 1'b0;
        if (stray_tog != stray_done) begin
            stray_done  = stray_tog;
            MBA_out_val = 1'b1;
            MBA_out     = 10'h123;
        end
        if (pend) begin
            cnt_m--;
            if (cnt_m <= 0) begin
                pend        = 1'b0;
                MBA_out_val = 1'b1;
                MBA_out     = prod;
            end
        end
        if (MBA_val) begin
            if (op_q.size() == 0) begin
                check(1'b0, $sformatf("mba_op unexpected strobe A=%h B=%h", MBA_A, MBA_B));
            end else begin
                exp_op = op_q.pop_front();
                check({MBA_A, MBA_B} === exp_op,
                      $sformatf("mba_op got A=%h B=%h expected A=%h B=%h",
                                MBA_A, MBA_B, exp_op[2*MI-1:MI], exp_op[MI-1:0]));
            end
            sa   = {{(MO-MI){MBA_A[MI-1]}}, MBA_A};
            sb   = {{(MO-MI){MBA_B[MI-1]}}, MBA_B};
            prod = sa * sb;
            if (core_on) begin
                if (lat == 0) begin
                    MBA_out_val = 1'b1;
                    MBA_out     = prod;
                end else begin
                    pend  = 1'b1;
                    cnt_m = lat;
                end
            end
        end else if (MBA_A !== '0 || MBA_B !== '0) begin
            check(1'b0, $sformatf("mba_op_idle got A=%h B=%h expected 0", MBA_A, MBA_B));
        end
    end

    // Response monitor.
    rsp_t exp_rsp;
    always @(negedge clock) begin
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check(1'b0, $sformatf("rsp unexpected err=%b id=%0d data=%h expected none",
                                      rsp_error, rsp_id, rsp_data));
            end else begin
                exp_rsp = rsp_q.pop_front();
                check({rsp_error, rsp_id, rsp_data} === exp_rsp,
                      $sformatf("rsp got err=%b id=%0d data=%h expected err=%b id=%0d data=%h",
                                rsp_error, rsp_id, rsp_data, exp_rsp.err, exp_rsp.id, exp_rsp.data));
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [AW-1:0] b);
        req_a[i*AW +: AW] = a;
        req_b[i*AW +: AW] = b;
    endtask

    task automatic push(input logic [MI-1:0] a, input logic [MI-1:0] b,
                        input logic err, input logic [IW-1:0] id, input logic [AW-1:0] data);
        op_q.push_back({a, b});
        rsp_q.push_back({err, id, data});
    endtask

    // Present mask and wait for n_acc accepts; hold keeps granted bits raised.
    task automatic issue(input logic [NR-1:0] mask, input int n_acc, input bit hold);
        int acc = 0;
        int cyc = 0;
        logic [NR-1:0] hit;
        req_valid = mask;
        while (acc < n_acc && cyc < 200) begin
            @(negedge clock);
            cyc++;
            hit = req_valid & req_ready;
            if (hit != '0) begin
                check($onehot(req_ready), $sformatf("ready_onehot got %b expected one bit", req_ready));
                acc++;
                @(posedge clock);
                #1;
                if (!hold) req_valid = req_valid & ~hit;
            end
        end
        if (acc < n_acc) check(1'b0, $sformatf("accept_timeout got %0d accepts expected %0d", acc, n_acc));
        req_valid = '0;
    endtask

    task automatic drain();
        int c = 0;
        while (rsp_q.size() != 0 && c < 100) begin
            @(negedge clock);
            c++;
        end
        if (rsp_q.size() != 0)
            check(1'b0, $sformatf("drain_timeout got %0d pending expected 0", rsp_q.size()));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [NR-1:0] mask);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = mask;
        @(posedge clock);
        @(negedge clock);
        check({req_ready, MBA_val, MBA_A, MBA_B, rsp_valid, rsp_data, rsp_id, rsp_error} === '0,
              $sformatf("reset_outputs got ready=%b val=%b A=%h B=%h rv=%b data=%h id=%0d err=%b expected all 0",
                        req_ready, MBA_val, MBA_A, MBA_B, rsp_valid, rsp_data, rsp_id, rsp_error));
        @(posedge clock);
        #1;
        reset     = 1'b1;
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset('0);

        // Grant order from reset with all requesters held: 0,1,2,3,0.
        for (int i = 0; i < NR; i++) set_req(i, AW'(i + 1), 32'hFFFF_FFFF);
        lat = 3;
        push(5'h01, 5'h1F, 1'b0, 2'd0, 32'hFFFF_FFFF);
        push(5'h02, 5'h1F, 1'b0, 2'd1, 32'hFFFF_FFFE);
        push(5'h03, 5'h1F, 1'b0, 2'd2, 32'hFFFF_FFFD);
        push(5'h04, 5'h1F, 1'b0, 2'd3, 32'hFFFF_FFFC);
        push(5'h01, 5'h1F, 1'b0, 2'd0, 32'hFFFF_FFFF);
        issue(4'b1111, 5, 1'b1);
        drain();

        // 3 * -2 = -6, sign-extended.
        set_req(0, 32'h0000_0003, 32'hFFFF_FFFE);
        lat = 2;
        push(5'h03, 5'h1E, 1'b0, 2'd0, 32'hFFFF_FFFA);
        issue(4'b0001, 1, 1'b0);
        drain();

        // Operand truncation: 0x25 -> 0x05, 0x41 -> 0x01.
        set_req(1, 32'h0000_0025, 32'h0000_0041);
        lat = 1;
        push(5'h05, 5'h01, 1'b0, 2'd1, 32'h0000_0005);
        issue(4'b0010, 1, 1'b0);
        drain();

        // Stray core strobe in IDLE, then a zero-latency transaction.
        stray_tog = ~stray_tog;
        repeat (3) @(posedge clock);
        #1;
        set_req(3, 32'hFFFF_FFFD, 32'h0000_0005);
        lat = 0;
        push(5'h1D, 5'h05, 1'b0, 2'd3, 32'hFFFF_FFF1);
        issue(4'b1000, 1, 1'b0);
        drain();

        // Reset during WAIT for requester 2 drops it; requester 0 then wins over 2.
        set_req(2, 32'h0000_0006, 32'h0000_0002);
        lat = 20;
        op_q.push_back({5'h06, 5'h02});
        issue(4'b0100, 1, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        set_req(0, 32'h0000_0007, 32'h0000_0003);
        set_req(2, 32'h0000_0001, 32'h0000_0001);
        do_reset(4'b0101);
        check(op_q.size() == 0, $sformatf("reset_op_queue got %0d pending expected 0", op_q.size()));
        lat = 2;
        push(5'h07, 5'h03, 1'b0, 2'd0, 32'h0000_0015);
        push(5'h01, 5'h01, 1'b0, 2'd2, 32'h0000_0001);
        issue(4'b0101, 2, 1'b0);
        drain();

`ifdef MBA_ARB_TIMEOUT_EN
        // Core never answers: watchdog response, then a normal transaction.
        core_on = 1'b0;
        set_req(1, 32'h0000_0009, 32'h0000_0009);
        push(5'h09, 5'h09, 1'b1, 2'd1, 32'h0000_0000);
        issue(4'b0010, 1, 1'b0);
        drain();
        core_on = 1'b1;
        set_req(2, 32'h0000_0002, 32'h0000_0003);
        lat = 1;
        push(5'h02, 5'h03, 1'b0, 2'd2, 32'h0000_0006);
        issue(4'b0100, 1, 1'b0);
        drain();
`endif

        repeat (5) @(posedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
